// File: rtl/block_mm_pkg.sv
// Shared types and constants for the block multiplier sequencer.
package block_mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mm_state_e;

    localparam int LANES    = 4;
    localparam int GROUPS   = 8;
    localparam int READ_LAT = 1;
    localparam int SKEW_MAX = 3;

    // Read latency, the output register, the deepest skew stage, then array propagation.
    function automatic int drain_len(input int drain_cycles);
        return READ_LAT + 1 + SKEW_MAX + drain_cycles;
    endfunction

endpackage

// File: rtl/block_mm_ctrl_skew_line.sv
// Fixed-depth delay line used to skew one operand lane; depth 0 is a wire.
module skew_line #(
    parameter int W     = 16,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_s;
            assign unused_s = clk ^ rst_n;
            assign dout     = din;
        end else begin : g_dly
            logic [W-1:0] pipe_r [DEPTH];

            // Shift the lane value one stage per cycle, cleared on reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe_r[i] <= {W{1'b0}};
                    end
                end else begin
                    pipe_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign dout = pipe_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/block_mm_ctrl.sv
// Sequencer streaming skewed operands into the eight 4x4 systolic arrays.
// Optional job cycle counter is built when BLOCK_MM_PERF_EN is defined.
module block_mm_ctrl
    import block_mm_pkg::*;
#(
    parameter  int BIT_WIDTH    = 16,
    parameter  int FRAC_WIDTH   = 8,
    parameter  int K_MAX        = 64,
    parameter  int DRAIN_CYCLES = 8,
    localparam int KW           = $clog2(K_MAX + 1),
    localparam int BUS_W        = GROUPS * LANES * BIT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KW-1:0]    k_len,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [KW-1:0]    rd_addr,
    input  logic [BUS_W-1:0] rd_data_a,
    input  logic [BUS_W-1:0] rd_data_b,
    output logic             array_rst_n,
    output logic [BUS_W-1:0] west_bus,
    output logic [BUS_W-1:0] north_bus,
    output logic [31:0]      perf_cycles
);

    // Q-format is the arrays' concern; this block only carries the parameter.
    localparam int frac_width_unused = FRAC_WIDTH;

    localparam logic [KW-1:0] K_MAX_C    = KW'(K_MAX);
    localparam logic [15:0]   DRAIN_LAST = 16'(drain_len(DRAIN_CYCLES) - 1);

    mm_state_e         state_r;
    logic [KW-1:0]     k_len_r;
    logic [15:0]       drain_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              rd_en_r;
    logic [KW-1:0]     rd_addr_r;
    logic              array_rst_n_r;
    logic              rd_vld_r;
    logic [BUS_W-1:0]  a_q_r;
    logic [BUS_W-1:0]  b_q_r;

    // Job sequencing FSM; every control output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            k_len_r       <= {KW{1'b0}};
            drain_cnt_r   <= 16'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            rd_en_r       <= 1'b0;
            rd_addr_r     <= {KW{1'b0}};
            array_rst_n_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r       <= ST_CLEAR;
                        k_len_r       <= (k_len > K_MAX_C) ? K_MAX_C : k_len;
                        busy_r        <= 1'b1;
                        array_rst_n_r <= 1'b0;
                    end else begin
                        array_rst_n_r <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    array_rst_n_r <= 1'b1;
                    if (k_len_r == {KW{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r   <= ST_FEED;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= {KW{1'b0}};
                    end
                end
                ST_FEED: begin
                    if (rd_addr_r == k_len_r - KW'(1'b1)) begin
                        state_r     <= ST_DRAIN;
                        rd_en_r     <= 1'b0;
                        rd_addr_r   <= {KW{1'b0}};
                        drain_cnt_r <= 16'd0;
                    end else begin
                        rd_addr_r <= rd_addr_r + KW'(1'b1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 16'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                    rd_en_r       <= 1'b0;
                    rd_addr_r     <= {KW{1'b0}};
                    array_rst_n_r <= 1'b1;
                end
            endcase
        end
    end

    // Capture read data only in its valid cycle so idle slots carry zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r <= 1'b0;
            a_q_r    <= {BUS_W{1'b0}};
            b_q_r    <= {BUS_W{1'b0}};
        end else begin
            rd_vld_r <= rd_en_r;
            a_q_r    <= rd_vld_r ? rd_data_a : {BUS_W{1'b0}};
            b_q_r    <= rd_vld_r ? rd_data_b : {BUS_W{1'b0}};
        end
    end

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            // Lane 0 sits in the top bits of its group.
            localparam int OFS = g * LANES * BIT_WIDTH + (LANES - 1 - l) * BIT_WIDTH;

            skew_line #(.W(BIT_WIDTH), .DEPTH(l)) u_west (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (a_q_r[OFS +: BIT_WIDTH]),
                .dout  (west_bus[OFS +: BIT_WIDTH])
            );

            skew_line #(.W(BIT_WIDTH), .DEPTH(l)) u_north (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (b_q_r[OFS +: BIT_WIDTH]),
                .dout  (north_bus[OFS +: BIT_WIDTH])
            );
        end
    end

`ifdef BLOCK_MM_PERF_EN
    logic [31:0] perf_r;

    // Count busy cycles of the current job; value holds once the job ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            perf_r <= 32'd0;
        end else if (busy_r) begin
            perf_r <= perf_r + 32'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_cycles = perf_r;
`else
    assign perf_cycles = 32'd0;
`endif

    assign busy        = busy_r;
    assign done        = done_r;
    assign rd_en       = rd_en_r;
    assign rd_addr     = rd_addr_r;
    assign array_rst_n = array_rst_n_r;

endmodule

// File: tb/tb_block_mm_ctrl.sv
// Randomized bench for block_mm_ctrl against a cycle-timeline reference model.
module tb_block_mm_ctrl;

    localparam int BW    = 16;
    localparam int K_MAX = 64;
    localparam int DC    = 8;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int BUS_W = 8 * 4 * BW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [KW-1:0]    k_len = '0;
    logic             busy, done, rd_en, array_rst_n;
    logic [KW-1:0]    rd_addr;
    logic [BUS_W-1:0] rd_data_a = '0;
    logic [BUS_W-1:0] rd_data_b = '0;
    logic [BUS_W-1:0] west_bus, north_bus;
    logic [31:0]      perf_cycles;

    block_mm_ctrl #(.BIT_WIDTH(BW), .FRAC_WIDTH(8), .K_MAX(K_MAX), .DRAIN_CYCLES(DC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .k_len       (k_len),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .array_rst_n (array_rst_n),
        .west_bus    (west_bus),
        .north_bus   (north_bus),
        .perf_cycles (perf_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: one job described by its start cycle and length.
    int cyc = 0;
    int s_cyc = 0;
    int d_cyc = 0;
    int kl = 0;
    int rise_cyc = 0;
    int job_cnt = 0;
    bit job_valid = 1'b0;
    logic [BUS_W-1:0] mem_a [128];
    logic [BUS_W-1:0] mem_b [128];

    task automatic check_val(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] r;
        for (int i = 0; i < BUS_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int sat_k(input int k);
        return (k > K_MAX) ? K_MAX : k;
    endfunction

    function automatic int done_at(input int s, input int k);
        return (k == 0) ? s + 2 : s + 2 + k + 5 + DC;
    endfunction

    // Operand buffer (garbage when not read) and job acceptance model.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_data_a <= rd_en ? mem_a[rd_addr] : rand_bus();
        rd_data_b <= rd_en ? mem_b[rd_addr] : rand_bus();
        if (!rst_n) begin
            job_valid <= 1'b0;
            rise_cyc  <= cyc + 1;
        end else if (start && cyc >= rise_cyc && (!job_valid || cyc > d_cyc)) begin
            s_cyc     <= cyc;
            kl        <= sat_k(int'(k_len));
            d_cyc     <= done_at(cyc, sat_k(int'(k_len)));
            job_valid <= 1'b1;
            job_cnt   <= job_cnt + 1;
        end
    end

    task automatic check_cycle();
        int c = cyc;
        int f = s_cyc + 2;
        logic e_busy = 1'b0, e_done = 1'b0, e_rd = 1'b0, e_arst = 1'b0;
        logic [KW-1:0] e_addr = '0;
        logic [BUS_W-1:0] e_w = '0, e_n = '0;
        logic [31:0] e_perf = 32'd0;
        if (rst_n) begin
            e_arst = (c > rise_cyc) && !(job_valid && c == s_cyc + 1);
            if (job_valid) begin
                e_busy = (c >= s_cyc + 1) && (c < d_cyc);
                e_done = (c == d_cyc);
                e_rd   = (c >= f) && (c < f + kl);
                if (e_rd) e_addr = KW'(c - f);
                for (int g = 0; g < 8; g++) begin
                    for (int l = 0; l < 4; l++) begin
                        int k = c - f - 2 - l;
                        int o = g * 64 + (3 - l) * 16;
                        if (k >= 0 && k < kl) begin
                            e_w[o +: 16] = mem_a[k][o +: 16];
                            e_n[o +: 16] = mem_b[k][o +: 16];
                        end
                    end
                end
`ifdef BLOCK_MM_PERF_EN
                e_perf = 32'(((c < d_cyc) ? c : d_cyc) - s_cyc - 1);
`endif
            end
        end
        check_val("busy", BUS_W'(busy), BUS_W'(e_busy));
        check_val("done", BUS_W'(done), BUS_W'(e_done));
        check_val("rd_en", BUS_W'(rd_en), BUS_W'(e_rd));
        if (!rst_n || e_rd) check_val("rd_addr", BUS_W'(rd_addr), BUS_W'(e_addr));
        check_val("array_rst_n", BUS_W'(array_rst_n), BUS_W'(e_arst));
        check_val("west_bus", west_bus, e_w);
        check_val("north_bus", north_bus, e_n);
        check_val("perf_cycles", BUS_W'(perf_cycles), BUS_W'(e_perf));
    endtask

    // Compare every DUT output each cycle, away from the clock edge.
    always @(posedge clk) begin
        #2;
        check_cycle();
    end

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (job_valid && cyc > d_cyc) return;
        end
        check_val("job_timeout", BUS_W'(1'b0), BUS_W'(1'b1));
    endtask

    task automatic run_job(input int k);
        @(negedge clk);
        k_len = KW'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = rand_bus();
            mem_b[i] = rand_bus();
        end
    endtask

    initial begin
        int n0;
        fill_rand();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single step of constant operands (1.0 x 2.0).
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = {32{16'h0100}};
            mem_b[i] = {32{16'h0200}};
        end
        run_job(1);

        // Identity in group 0, random elsewhere.
        fill_rand();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 4; r++) begin
                mem_a[k][(3 - r) * 16 +: 16] = (r == k) ? 16'h0100 : 16'h0000;
                mem_b[k][(3 - r) * 16 +: 16] = (r == k) ? 16'h0100 : 16'h0000;
            end
        end
        run_job(4);

        run_job(0);

        // Start held high across a job: mid-job requests must be ignored.
        fill_rand();
        @(negedge clk);
        k_len = KW'(2);
        start = 1'b1;
        n0 = job_cnt;
        for (int i = 0; i < 200 && job_cnt < n0 + 2; i++) @(negedge clk);
        start = 1'b0;
        if (job_cnt < n0 + 2) check_val("held_start_timeout", BUS_W'(job_cnt), BUS_W'(n0 + 2));
        wait_idle();

        // Oversized length saturates.
        fill_rand();
        run_job(K_MAX + 5);

        // Reset in the middle of FEED with k_len=8, at F+3.
        @(negedge clk);
        k_len = KW'(8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Random jobs with random gaps.
        for (int j = 0; j < 8; j++) begin
            fill_rand();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_job($urandom_range(0, K_MAX + 6));
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
